// File: rtl/fe_pkg.sv
// Shared front-end definitions.
// Holds the branch-op encoding decoded by the predictor and helpers that produce the
// weak-taken / weak-not-taken counter initial values for any counter width.
package fe_pkg;

  // Two-bit branch op carried by the fetched instruction.
  typedef enum logic [1:0] {
    BR_CC = 2'b00,  // conditional
    BR_B  = 2'b01,  // unconditional
    BR_BL = 2'b10,  // call (link)
    BR_BX = 2'b11   // return
  } branch_op_e;

  // Weakly taken: 10...0. Callers slice the low 'width' bits.
  function automatic logic [31:0] ctr_weak_taken(input int unsigned width);
    logic [31:0] v;
    v = 32'd1 << (width - 1);
    return v;
  endfunction

  // Weakly not-taken: 01...1. Callers slice the low 'width' bits.
  function automatic logic [31:0] ctr_weak_not_taken(input int unsigned width);
    logic [31:0] v;
    v = (32'd1 << (width - 1)) - 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return address stack.
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset
//   push_i, addr_i  : push addr_i (overwrites the oldest entry when full)
//   pop_i           : pop top entry (no-op when empty)
//   flush_i         : empty the stack; overrides push/pop in the same cycle
//   top_o, valid_o  : top entry (0 when empty) and non-empty flag
module return_address_stack #(
  parameter int unsigned pc_width_p  = 16,
  parameter int unsigned ras_depth_p = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [pc_width_p-1:0] addr_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [pc_width_p-1:0] top_o,
  output logic                  valid_o
);

  localparam int unsigned PtrW = $clog2(ras_depth_p);
  localparam int unsigned CntW = $clog2(ras_depth_p + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(ras_depth_p);

  logic [pc_width_p-1:0] r_mem [ras_depth_p];
  // r_ptr is the next write slot; the top lives one below it.
  logic [PtrW-1:0]       r_ptr;
  logic [CntW-1:0]       r_count;
  logic [PtrW-1:0]       w_top_ptr;

  assign w_top_ptr = r_ptr - PtrW'(1);
  assign valid_o   = (r_count != '0);
  assign top_o     = valid_o ? r_mem[w_top_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr   <= '0;
      r_count <= '0;
      for (int i = 0; i < ras_depth_p; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_count <= '0;
    end else if (push_i) begin
      r_mem[r_ptr] <= addr_i;
      r_ptr        <= r_ptr + PtrW'(1);
      if (r_count != CntMax) begin
        r_count <= r_count + CntW'(1);
      end
    end else if (pop_i && valid_o) begin
      r_ptr   <= w_top_ptr;
      r_count <= r_count - CntW'(1);
    end
  end

endmodule

// File: rtl/dynamic_branch_control.sv
// Front-end dynamic branch predictor.
// Decodes the fetched branch op and returns take/speculative decisions. CC branches use a
// table of saturating counters (with valid bits) trained by backend resolution; an invalid
// entry falls back to static backward-taken. BX returns are predicted from a RAS.
// Ports:
//   clk_i, reset_i                      : clock, synchronous active-high reset
//   pc_i, is_branch_i, sign_bit_i,
//   branch_op_code_i, fire_i            : prediction request; fire_i commits RAS push/pop
//   take_branch_o, speculative_o        : prediction
//   ras_target_o, ras_valid_o           : RAS top (0 when empty) and non-empty flag
//   resolve_v_i, resolve_pc_i,
//   resolve_taken_i                     : CC branch resolution for training
//   mispredict_i                        : backend redirect; flushes the RAS
module dynamic_branch_control
  import fe_pkg::*;
#(
  parameter int unsigned pc_width_p    = 16,
  parameter int unsigned bht_entries_p = 64,
  parameter int unsigned ctr_width_p   = 2,
  parameter int unsigned ras_depth_p   = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [pc_width_p-1:0] pc_i,
  input  logic                  is_branch_i,
  input  logic                  sign_bit_i,
  input  logic [1:0]            branch_op_code_i,
  input  logic                  fire_i,
  output logic                  take_branch_o,
  output logic                  speculative_o,
  output logic [pc_width_p-1:0] ras_target_o,
  output logic                  ras_valid_o,
  input  logic                  resolve_v_i,
  input  logic [pc_width_p-1:0] resolve_pc_i,
  input  logic                  resolve_taken_i,
  input  logic                  mispredict_i
);

  localparam int unsigned IdxW = $clog2(bht_entries_p);
  localparam logic [31:0] WeakT32  = ctr_weak_taken(ctr_width_p);
  localparam logic [31:0] WeakNT32 = ctr_weak_not_taken(ctr_width_p);
  localparam logic [ctr_width_p-1:0] CtrWeakT  = WeakT32[ctr_width_p-1:0];
  localparam logic [ctr_width_p-1:0] CtrWeakNT = WeakNT32[ctr_width_p-1:0];

  logic [bht_entries_p-1:0] r_valid;
  logic [ctr_width_p-1:0]   r_ctr [bht_entries_p];

  logic [IdxW-1:0]       w_pred_idx;
  logic [IdxW-1:0]       w_res_idx;
  logic                  w_take;
  logic                  w_spec;
  logic                  w_push;
  logic                  w_pop;
  logic [pc_width_p-1:0] w_ret_addr;
  logic [pc_width_p-1:0] w_ras_top;
  logic                  w_ras_valid;
  logic                  w_unused_resolve_pc;

  // Only the index bits of the resolve PC address the table.
  assign w_unused_resolve_pc = ^resolve_pc_i;

  assign w_pred_idx = pc_i[IdxW-1:0];
  assign w_res_idx  = resolve_pc_i[IdxW-1:0];
  assign w_ret_addr = pc_i + pc_width_p'(1);

  // Decode reads the registered table, so a same-cycle resolve is not seen here.
  always_comb begin
    w_take = 1'b0;
    w_spec = 1'b0;
    w_push = 1'b0;
    w_pop  = 1'b0;
    if (is_branch_i) begin
      unique case (branch_op_e'(branch_op_code_i))
        BR_CC: begin
          w_spec = 1'b1;
          w_take = r_valid[w_pred_idx] ? r_ctr[w_pred_idx][ctr_width_p-1] : sign_bit_i;
        end
        BR_B: begin
          w_take = 1'b1;
        end
        BR_BL: begin
          w_take = 1'b1;
          w_push = fire_i;
        end
        BR_BX: begin
          w_spec = 1'b1;
          w_take = w_ras_valid;
          w_pop  = fire_i && w_ras_valid;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid <= '0;
      for (int i = 0; i < bht_entries_p; i++) begin
        r_ctr[i] <= CtrWeakNT;
      end
    end else if (resolve_v_i) begin
      if (!r_valid[w_res_idx]) begin
        r_valid[w_res_idx] <= 1'b1;
        r_ctr[w_res_idx]   <= resolve_taken_i ? CtrWeakT : CtrWeakNT;
      end else if (resolve_taken_i) begin
        if (r_ctr[w_res_idx] != '1) begin
          r_ctr[w_res_idx] <= r_ctr[w_res_idx] + ctr_width_p'(1);
        end
      end else if (r_ctr[w_res_idx] != '0) begin
        r_ctr[w_res_idx] <= r_ctr[w_res_idx] - ctr_width_p'(1);
      end
    end
  end

  return_address_stack #(
    .pc_width_p (pc_width_p),
    .ras_depth_p(ras_depth_p)
  ) u_ras (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (w_push),
    .addr_i (w_ret_addr),
    .pop_i  (w_pop),
    .flush_i(mispredict_i),
    .top_o  (w_ras_top),
    .valid_o(w_ras_valid)
  );

  assign take_branch_o = w_take;
  assign speculative_o = w_spec;
  assign ras_target_o  = w_ras_top;
  assign ras_valid_o   = w_ras_valid;

endmodule

// File: tb/tb_dynamic_branch_control.sv
// Directed bench for dynamic_branch_control: expected outputs are queued as each step is
// driven and popped/compared once the combinational outputs have settled.
module tb_dynamic_branch_control;

  localparam logic [1:0] OpCc = 2'b00;
  localparam logic [1:0] OpB  = 2'b01;
  localparam logic [1:0] OpBl = 2'b10;
  localparam logic [1:0] OpBx = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        is_branch;
  logic        sign_bit;
  logic [1:0]  op;
  logic        fire;
  logic        take;
  logic        spec;
  logic [15:0] ras_target;
  logic        ras_valid;
  logic        resolve_v;
  logic [15:0] resolve_pc;
  logic        resolve_taken;
  logic        mispredict;

  typedef struct {
    string       tag;
    logic        take;
    logic        spec;
    logic        valid;
    logic [15:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dynamic_branch_control #(
    .pc_width_p   (16),
    .bht_entries_p(64),
    .ctr_width_p  (2),
    .ras_depth_p  (4)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .pc_i            (pc),
    .is_branch_i     (is_branch),
    .sign_bit_i      (sign_bit),
    .branch_op_code_i(op),
    .fire_i          (fire),
    .take_branch_o   (take),
    .speculative_o   (spec),
    .ras_target_o    (ras_target),
    .ras_valid_o     (ras_valid),
    .resolve_v_i     (resolve_v),
    .resolve_pc_i    (resolve_pc),
    .resolve_taken_i (resolve_taken),
    .mispredict_i    (mispredict)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic ib, input logic sb, input logic [1:0] o,
                       input logic [15:0] p, input logic f);
    is_branch = ib;
    sign_bit  = sb;
    op        = o;
    pc        = p;
    fire      = f;
  endtask

  task automatic res(input logic [15:0] p, input logic t);
    resolve_v     = 1'b1;
    resolve_pc    = p;
    resolve_taken = t;
  endtask

  // Queue the expectation, compare after settling, then advance one cycle.
  task automatic step(input string tag, input logic et, input logic es, input logic ev,
                      input logic [15:0] eg);
    exp_t e;
    exp_t got;
    e.tag = tag; e.take = et; e.spec = es; e.valid = ev; e.target = eg;
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    chk({got.tag, "_take"},   16'(take),       16'(got.take));
    chk({got.tag, "_spec"},   16'(spec),       16'(got.spec));
    chk({got.tag, "_valid"},  16'(ras_valid),  16'(got.valid));
    chk({got.tag, "_target"}, ras_target,      got.target);
    @(negedge clk);
    fire       = 1'b0;
    resolve_v  = 1'b0;
    mispredict = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; resolve_v = 1'b0; resolve_pc = '0; resolve_taken = 1'b0;
    mispredict = 1'b0;
    drive(1'b0, 1'b0, OpCc, 16'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state and static decode
    drive(1'b1, 1'b1, OpCc, 16'h0005, 1'b0); step("cc_back_rst", 1, 1, 0, 16'h0);
    drive(1'b1, 1'b0, OpCc, 16'h0005, 1'b0); step("cc_fwd_rst",  0, 1, 0, 16'h0);
    drive(1'b1, 1'b0, OpB,  16'h0005, 1'b0); step("b",           1, 0, 0, 16'h0);
    drive(1'b0, 1'b0, OpBl, 16'h0005, 1'b1); step("nonbranch",   0, 0, 0, 16'h0);
    drive(1'b1, 1'b0, OpBx, 16'h0005, 1'b1); step("bx_empty0",   0, 1, 0, 16'h0);

    // Training taken: first resolve sees invalid entry (pre-update) -> static forward
    drive(1'b1, 1'b0, OpCc, 16'h0005, 1'b0);
    res(16'h0005, 1'b1); step("tr_t1", 0, 1, 0, 16'h0);  // -> 10
    res(16'h0005, 1'b1); step("tr_t2", 1, 1, 0, 16'h0);  // -> 11
    res(16'h0005, 1'b1); step("tr_t3", 1, 1, 0, 16'h0);  // sat 11
    step("pred_t", 1, 1, 0, 16'h0);
    drive(1'b1, 1'b0, OpCc, 16'h0045, 1'b0); step("alias_t", 1, 1, 0, 16'h0);

    // Training not-taken, saturating at 00
    drive(1'b1, 1'b0, OpCc, 16'h0005, 1'b0);
    res(16'h0005, 1'b0); step("tr_n1", 1, 1, 0, 16'h0);  // 11 -> 10
    res(16'h0005, 1'b0); step("tr_n2", 1, 1, 0, 16'h0);  // 10 -> 01
    res(16'h0005, 1'b0); step("tr_n3", 0, 1, 0, 16'h0);  // 01 -> 00
    res(16'h0005, 1'b0); step("tr_n4", 0, 1, 0, 16'h0);  // sat 00
    res(16'h0005, 1'b1); step("pred_n", 0, 1, 0, 16'h0); // 00 -> 01
    res(16'h0005, 1'b1); step("sat_lo", 0, 1, 0, 16'h0); // 01 -> 10
    drive(1'b1, 1'b0, OpCc, 16'h0045, 1'b0); step("alias_t2", 1, 1, 0, 16'h0);

    // Call/return pairing
    drive(1'b1, 1'b0, OpBl, 16'h0100, 1'b1); step("bl1",  1, 0, 0, 16'h0);
    drive(1'b1, 1'b0, OpBl, 16'h0200, 1'b1); step("bl2",  1, 0, 1, 16'h0101);
    drive(1'b1, 1'b0, OpBx, 16'h0300, 1'b0); step("bx_nofire", 1, 1, 1, 16'h0201);
    drive(1'b1, 1'b0, OpBx, 16'h0300, 1'b1); step("bx1",  1, 1, 1, 16'h0201);
    drive(1'b1, 1'b0, OpBx, 16'h0300, 1'b1); step("bx2",  1, 1, 1, 16'h0101);
    drive(1'b1, 1'b0, OpBx, 16'h0300, 1'b1); step("bx3",  0, 1, 0, 16'h0);

    // Overflow: five pushes into four entries overwrite the oldest
    drive(1'b1, 1'b0, OpBl, 16'h0010, 1'b1); step("ov_p1", 1, 0, 0, 16'h0);
    drive(1'b1, 1'b0, OpBl, 16'h0020, 1'b1); step("ov_p2", 1, 0, 1, 16'h0011);
    drive(1'b1, 1'b0, OpBl, 16'h0030, 1'b1); step("ov_p3", 1, 0, 1, 16'h0021);
    drive(1'b1, 1'b0, OpBl, 16'h0040, 1'b1); step("ov_p4", 1, 0, 1, 16'h0031);
    drive(1'b1, 1'b0, OpBl, 16'h0050, 1'b1); step("ov_p5", 1, 0, 1, 16'h0041);
    drive(1'b1, 1'b0, OpBx, 16'h0000, 1'b1); step("ov_x1", 1, 1, 1, 16'h0051);
    drive(1'b1, 1'b0, OpBx, 16'h0000, 1'b1); step("ov_x2", 1, 1, 1, 16'h0041);
    drive(1'b1, 1'b0, OpBx, 16'h0000, 1'b1); step("ov_x3", 1, 1, 1, 16'h0031);
    drive(1'b1, 1'b0, OpBx, 16'h0000, 1'b1); step("ov_x4", 1, 1, 1, 16'h0021);
    drive(1'b1, 1'b0, OpBx, 16'h0000, 1'b1); step("ov_x5", 0, 1, 0, 16'h0);

    // Pop on empty is a no-op; then mispredict flushes and blocks the same-cycle push
    drive(1'b1, 1'b0, OpBl, 16'hffff, 1'b1); step("wrap_push", 1, 0, 0, 16'h0);
    drive(1'b1, 1'b0, OpBl, 16'h0060, 1'b1); step("push60", 1, 0, 1, 16'h0000);
    drive(1'b1, 1'b0, OpBl, 16'h0070, 1'b1);
    mispredict = 1'b1;                        step("mis_bl", 1, 0, 1, 16'h0061);
    drive(1'b1, 1'b0, OpBx, 16'h0000, 1'b0); step("mis_empty", 0, 1, 0, 16'h0);
    drive(1'b1, 1'b0, OpCc, 16'h0005, 1'b0); step("mis_tbl", 1, 1, 0, 16'h0);

    // Reset mid-training has priority over resolve and fire
    drive(1'b1, 1'b0, OpCc, 16'h0009, 1'b0);
    res(16'h0009, 1'b1); step("rt_t1", 0, 1, 0, 16'h0);
    res(16'h0009, 1'b1); step("rt_t2", 1, 1, 0, 16'h0);
    drive(1'b1, 1'b0, OpBl, 16'h0080, 1'b1); step("rt_push", 1, 0, 0, 16'h0);
    drive(1'b1, 1'b0, OpCc, 16'h0009, 1'b1);
    reset = 1'b1;
    res(16'h0009, 1'b1); step("rt_rst", 1, 1, 1, 16'h0081);
    reset = 1'b0;
    drive(1'b1, 1'b0, OpCc, 16'h0009, 1'b0); step("rt_fwd", 0, 1, 0, 16'h0);
    drive(1'b1, 1'b1, OpCc, 16'h0009, 1'b0); step("rt_back", 1, 1, 0, 16'h0);
    drive(1'b1, 1'b0, OpBx, 16'h0009, 1'b0); step("rt_bx", 0, 1, 0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
